pipeline_hazard_ctrl: RTL



---
 rtl/pipeline_hazard_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the five-stage pipeline with caches.
// Resolves load-use hazards, execute-stage redirects and I/D cache misses,
// and keeps wrapping counters of stalled fetch cycles and accepted redirects.
module pipeline_hazard_ctrl #(
   parameter int REG_ADDR_WIDTH = 5,
   parameter int CNT_WIDTH      = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [REG_ADDR_WIDTH-1:0] Rs1_d,
   input  logic [REG_ADDR_WIDTH-1:0] Rs2_d,
   input  logic                      valid_d,
   input  logic [REG_ADDR_WIDTH-1:0] Rd_e,
   input  logic                      RegWrite_e,
   input  logic [1:0]                ResultSrc_e,
   input  logic                      valid_e,
   input  logic                      PCSrc_e,
   input  logic                      imiss,
   input  logic                      imiss_done,
   input  logic                      dmiss,
   input  logic                      dmiss_done,
   output logic                      en_pc,
   output logic                      en_fd,
   output logic                      en_de,
   output logic                      en_em,
   output logic                      en_mw,
   output logic                      flush_n_fd,
   output logic                      flush_n_de,
   output logic [CNT_WIDTH-1:0]      stall_cnt,
   output logic [CNT_WIDTH-1:0]      flush_cnt
);

   typedef enum logic [1:0] {
      S_RUN,
      S_DMISS,
      S_IMISS,
      S_IMISS_REDIR
   } state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   state_t               state_q, state_d;
   logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

   logic load_use;
   logic redirect_req;
   logic redirect_acc;
   logic freeze;
   logic front_miss;

   // Hazard detection terms derived straight from the stage contents.
   always_comb begin
      load_use     = valid_e & RegWrite_e & (ResultSrc_e == 2'b01) &
                     (Rd_e != '0) & valid_d &
                     ((Rd_e == Rs1_d) | (Rd_e == Rs2_d));
      redirect_req = PCSrc_e & valid_e;
      freeze       = dmiss | (state_q == S_DMISS);
      front_miss   = (state_q == S_IMISS) | (state_q == S_IMISS_REDIR);
   end

   // Next-state and zero-latency enable/flush outputs, highest priority first.
   always_comb begin
      en_pc        = 1'b1;
      en_fd        = 1'b1;
      en_de        = 1'b1;
      en_em        = 1'b1;
      en_mw        = 1'b1;
      flush_n_fd   = 1'b1;
      flush_n_de   = 1'b1;
      redirect_acc = 1'b0;
      state_d      = state_q;

      if (rst) begin
         en_pc      = 1'b0;
         en_fd      = 1'b0;
         en_de      = 1'b0;
         en_em      = 1'b0;
         en_mw      = 1'b0;
         flush_n_fd = 1'b0;
         flush_n_de = 1'b0;
         state_d    = S_RUN;
      end else if (freeze) begin
         // Whole pipe frozen until the data refill completes.
         en_pc   = 1'b0;
         en_fd   = 1'b0;
         en_de   = 1'b0;
         en_em   = 1'b0;
         en_mw   = 1'b0;
         state_d = dmiss_done ? S_RUN : S_DMISS;
      end else if (redirect_req) begin
         // PC takes the target; the two younger slots are wrong-path.
         redirect_acc = 1'b1;
         flush_n_fd   = 1'b0;
         flush_n_de   = 1'b0;
         if (front_miss) begin
            en_fd   = imiss_done;
            state_d = imiss_done ? S_RUN : S_IMISS_REDIR;
         end else begin
            // A fetch miss already in flight is for the old path.
            state_d = (imiss & ~imiss_done) ? S_IMISS_REDIR : S_RUN;
         end
      end else if (load_use) begin
         en_pc      = 1'b0;
         en_fd      = 1'b0;
         flush_n_de = 1'b0;
         // Do not lose a refill completion that lands on a bubble cycle.
         if (front_miss && imiss_done) begin
            state_d = S_RUN;
         end
      end else if (front_miss) begin
         if (imiss_done) begin
            // Fetch data from a miss issued before a redirect is discarded.
            flush_n_fd = (state_q != S_IMISS_REDIR);
            state_d    = S_RUN;
         end else begin
            en_pc      = 1'b0;
            en_fd      = 1'b0;
            flush_n_de = 1'b0;
         end
      end else if (imiss) begin
         en_pc      = 1'b0;
         en_fd      = 1'b0;
         flush_n_de = 1'b0;
         state_d    = imiss_done ? S_RUN : S_IMISS;
      end
   end

   // Performance counters: fetch-stall cycles and accepted redirects, wrapping.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (rst) begin
         stall_cnt_d = '0;
         flush_cnt_d = '0;
      end else begin
         if (!en_fd) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
         end
         if (redirect_acc) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
         end
      end
   end

   // State and counter registers.
   always_ff @(posedge clk) begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule
